// File: rtl/div_seq32_pkg.sv
// div_seq32: shared types and constants
// for the sequential RV32M divider.
package div_seq32_pkg;

  localparam int XLEN     = 32;
  localparam int ITER_CNT = 32;
  localparam int CNT_W    = 6;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ABS_A,
    S_ABS_B,
    S_ITER,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  function automatic logic is_signed(op_e op);
    return !op[0];
  endfunction

endpackage

// File: rtl/div_seq32_if.sv
// div_seq32: request/response handshake
// bundle between EXU and divider.
interface div_seq32_if;
  import div_seq32_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [1:0]      op;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, op, dividend, divisor,
    output flush, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, op, dividend, divisor,
    input  flush, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/div_seq32_adder_suber32.sv
// div_seq32: the single 32-bit adder/subtractor
// shared by negation, iteration and fix-up.
module adder_suber32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sub,
  output logic [31:0] sum,
  output logic        cout,
  output logic        zero,
  output logic        overflow
);

  logic [31:0] b_x;

  assign b_x = b ^ {32{sub}};

  assign {cout, sum} = {1'b0, a}
                     + {1'b0, b_x}
                     + 33'(sub);

  assign zero = (sum == '0);

  assign overflow = (a[31] == b_x[31])
                 && (sum[31] != a[31]);

endmodule

// File: rtl/div_seq32.sv
// div_seq32: multi-cycle DIV/DIVU/REM/REMU
// built around one shared adder/subtractor.
module div_seq32
  import div_seq32_pkg::*;
(
  input logic        clk,
  input logic        rst_n,
  div_seq32_if.slave io
);

  state_e state_q, state_d;
  op_e    op_q, op_d;
  op_e    in_op;

  logic [XLEN-1:0]  r_q, r_d;
  logic [XLEN-1:0]  q_q, q_d;
  logic [XLEN-1:0]  d_q, d_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;

  logic [XLEN-1:0] add_a, add_b, add_sum;
  logic            add_sub, add_cout;
  logic            zero_unused, ovf_unused;

  logic [XLEN-1:0] r_sh, sel;
  logic            take, sgn;

  assign in_op = op_e'(io.op);

  adder_suber32 u_add (
    .a        (add_a),
    .b        (add_b),
    .sub      (add_sub),
    .sum      (add_sum),
    .cout     (add_cout),
    .zero     (zero_unused),
    .overflow (ovf_unused)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    r_d       = r_q;
    q_d       = q_q;
    d_d       = d_q;
    res_d     = res_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    add_a     = '0;
    add_b     = '0;
    add_sub   = 1'b0;
    r_sh      = {r_q[XLEN-2:0], q_q[XLEN-1]};
    sel       = op_q[1] ? r_q : q_q;
    take      = 1'b0;
    sgn       = is_signed(in_op);

    unique case (state_q)
      S_IDLE: begin
        if (io.in_valid && !io.flush) begin
          op_d      = in_op;
          q_d       = io.dividend;
          d_d       = io.divisor;
          r_d       = '0;
          neg_quo_d = sgn
                    & (io.dividend[XLEN-1]
                    ^  io.divisor[XLEN-1]);
          neg_rem_d = sgn & io.dividend[XLEN-1];
          if (io.divisor == '0) begin
            res_d   = in_op[1] ? io.dividend : '1;
            state_d = S_DONE;
          end else if (sgn
                 && io.dividend == 32'h8000_0000
                 && io.divisor == '1) begin
            res_d   = in_op[1] ? '0 : 32'h8000_0000;
            state_d = S_DONE;
          end else begin
            state_d = S_ABS_A;
          end
        end
      end
      S_ABS_A: begin
        add_b   = q_q;
        add_sub = 1'b1;
        if (is_signed(op_q) && q_q[XLEN-1])
          q_d = add_sum;
        state_d = S_ABS_B;
      end
      S_ABS_B: begin
        add_b   = d_q;
        add_sub = 1'b1;
        if (is_signed(op_q) && d_q[XLEN-1])
          d_d = add_sum;
        cnt_d   = CNT_W'(ITER_CNT - 1);
        state_d = S_ITER;
      end
      S_ITER: begin
        add_a   = r_sh;
        add_b   = d_q;
        add_sub = 1'b1;
        // r_q[31] is the 33rd remainder bit
        take    = r_q[XLEN-1] | add_cout;
        r_d     = take ? add_sum : r_sh;
        q_d     = {q_q[XLEN-2:0], take};
        if (cnt_q == '0)
          state_d = S_FIX;
        else
          cnt_d = cnt_q - 1'b1;
      end
      S_FIX: begin
        add_b   = sel;
        add_sub = 1'b1;
        if (op_q[1] ? neg_rem_q : neg_quo_q)
          res_d = add_sum;
        else
          res_d = sel;
        state_d = S_DONE;
      end
      S_DONE: begin
        if (io.out_ready)
          state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && io.flush)
      state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      op_q      <= OP_DIV;
      r_q       <= '0;
      q_q       <= '0;
      d_q       <= '0;
      res_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      r_q       <= r_d;
      q_q       <= q_d;
      d_q       <= d_d;
      res_q     <= res_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
    end
  end

  assign io.in_ready  = (state_q == S_IDLE);
  assign io.busy      = (state_q != S_IDLE);
  assign io.out_valid = (state_q == S_DONE);
  assign io.result    = res_q;

endmodule

// File: tb/tb_div_seq32.sv
// div_seq32 bench: directed corner cases plus
// random ops against an arithmetic model.
module tb_div_seq32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  div_seq32_if io ();

  div_seq32 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  localparam int NORM_LAT = 35;
  localparam int SPEC_LAT = 0;
  localparam int WAIT_MAX = 100;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %h, expected %h",
             tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_div(
      input logic [1:0]  op,
      input logic [31:0] a,
      input logic [31:0] b);
    longint sa, sb;
    if (b == 0)
      return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'h0, a});
      sb = longint'({32'h0, b});
    end
    return op[1] ? 32'(sa % sb) : 32'(sa / sb);
  endfunction

  function automatic int ref_lat(
      input logic [1:0]  op,
      input logic [31:0] a,
      input logic [31:0] b);
    if (b == 0) return SPEC_LAT;
    if (!op[0] && a == 32'h8000_0000
        && b == 32'hFFFF_FFFF) return SPEC_LAT;
    return NORM_LAT;
  endfunction

  task automatic accept(input logic [1:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input string tag);
    io.op       = op;
    io.dividend = a;
    io.divisor  = b;
    io.in_valid = 1'b1;
    #1;
    chk({tag, ".in_ready"}, 32'(io.in_ready), 32'd1);
    @(posedge clk);
    #1 io.in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!io.out_valid && lat < WAIT_MAX) begin
      @(posedge clk);
      #1 lat++;
    end
  endtask

  task automatic run_op(input logic [1:0]  op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [31:0] exp,
                        input int exp_lat,
                        input string tag);
    int lat;
    accept(op, a, b, tag);
    wait_out(lat);
    chk({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, ".res"}, io.result, exp);
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    chk({tag, ".rdy_after"}, 32'(io.in_ready), 32'd1);
  endtask

  initial begin
    int lat;
    logic [31:0] held;
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    logic        seen;

    io.in_valid  = 1'b0;
    io.op        = 2'b00;
    io.dividend  = '0;
    io.divisor   = '0;
    io.flush     = 1'b0;
    io.out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", 32'(io.busy), 32'd0);
    chk("rst.out_valid", 32'(io.out_valid), 32'd0);
    chk("rst.result", io.result, 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rst.in_ready", 32'(io.in_ready), 32'd1);

    run_op(2'b01, 100, 7, 14, NORM_LAT, "divu100_7");
    run_op(2'b11, 100, 7, 2, NORM_LAT, "remu100_7");
    run_op(2'b00, 32'hFFFF_FFF9, 2,
           32'hFFFF_FFFD, NORM_LAT, "div_m7_2");
    run_op(2'b10, 32'hFFFF_FFF9, 2,
           32'hFFFF_FFFF, NORM_LAT, "rem_m7_2");
    run_op(2'b10, 7, 32'hFFFF_FFFE,
           1, NORM_LAT, "rem_7_m2");
    run_op(2'b00, 5, 0, 32'hFFFF_FFFF,
           SPEC_LAT, "div_5_0");
    run_op(2'b11, 5, 0, 5, SPEC_LAT, "remu_5_0");
    run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF,
           32'h8000_0000, SPEC_LAT, "div_ovf");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           0, SPEC_LAT, "rem_ovf");
    run_op(2'b01, 32'hFFFF_FFFF, 1,
           32'hFFFF_FFFF, NORM_LAT, "divu_max_1");
    run_op(2'b11, 32'hFFFF_FFFF, 32'h8000_0000,
           32'h7FFF_FFFF, NORM_LAT, "remu_max_msb");
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           1, NORM_LAT, "divu_max_max");

    // backpressure: result must hold while stalled
    accept(2'b00, 1000, 3, "bp");
    wait_out(lat);
    chk("bp.lat", 32'(lat), 32'(NORM_LAT));
    held = io.result;
    chk("bp.res", held, 32'd333);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("bp.hold", io.result, 32'd333);
      chk("bp.in_ready", 32'(io.in_ready), 32'd0);
      chk("bp.valid", 32'(io.out_valid), 32'd1);
    end
    io.out_ready = 1'b1;
    @(posedge clk);
    #1 io.out_ready = 1'b0;
    chk("bp.rdy_after", 32'(io.in_ready), 32'd1);

    // flush at ITER step 10
    accept(2'b01, 32'h1234_5678, 9, "fl");
    repeat (12) @(posedge clk);
    #1 chk("fl.busy_pre", 32'(io.busy), 32'd1);
    io.flush = 1'b1;
    @(posedge clk);
    #1 io.flush = 1'b0;
    chk("fl.busy", 32'(io.busy), 32'd0);
    chk("fl.valid", 32'(io.out_valid), 32'd0);
    chk("fl.in_ready", 32'(io.in_ready), 32'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 seen = seen | io.out_valid | io.busy;
    end
    chk("fl.quiet", 32'(seen), 32'd0);

    // flush in IDLE blocks a simultaneous request
    io.op       = 2'b01;
    io.dividend = 50;
    io.divisor  = 5;
    io.in_valid = 1'b1;
    io.flush    = 1'b1;
    @(posedge clk);
    #1;
    io.in_valid = 1'b0;
    io.flush    = 1'b0;
    chk("fl_idle.busy", 32'(io.busy), 32'd0);

    // reset in the middle of ITER
    accept(2'b00, 32'hDEAD_BEEF, 77, "rst_mid");
    repeat (20) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid.busy", 32'(io.busy), 32'd0);
    chk("rst_mid.valid", 32'(io.out_valid), 32'd0);
    chk("rst_mid.result", io.result, 32'd0);
    chk("rst_mid.in_ready", 32'(io.in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_op(2'b01, 100, 7, 14, NORM_LAT, "post_rst");

    // random ops with some corner bias
    for (int i = 0; i < 40; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2: begin
          ra = 32'($urandom_range(0, 300));
          rb = 32'($urandom_range(1, 20));
        end
        3: rb = 32'($urandom_range(1, 16)) ^ {32{ra[0]}};
        default: ;
      endcase
      run_op(rop, ra, rb, ref_div(rop, ra, rb),
             ref_lat(rop, ra, rb), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
